// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel-clock divider, H/V counters, registered sync/blank/coordinates and colour source.
// Define VGA_TEST_PATTERN_EN to build in the bars/checker/border patterns; otherwise every mode acts as mode 0.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int COLOR_W  = 4,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic               sw_r,
  input  logic               sw_g,
  input  logic               sw_b,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic [XW-1:0]      pix_x,
  output logic [YW-1:0]      pix_y,
  output logic               active,
  output logic               frame_start,
  output logic               pix_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;
  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic [1:0]    mode_q;
  logic [1:0]    mode_eff;
  logic [2:0]    rgb_on;
  logic          tick, h_last, v_last, at_origin, vis, hs_on, vs_on;

  assign tick      = (div == DW'(CLK_DIV - 1));
  assign h_last    = (h_cnt == XW'(H_TOTAL - 1));
  assign v_last    = (v_cnt == YW'(V_TOTAL - 1));
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign vis       = (h_cnt <= XW'(H_ACTIVE - 1)) && (v_cnt <= YW'(V_ACTIVE - 1));
  assign hs_on     = (h_cnt >= XW'(H_ACTIVE + H_FP)) && (h_cnt <= XW'(H_ACTIVE + H_FP + H_SYNC - 1));
  assign vs_on     = (v_cnt >= YW'(V_ACTIVE + V_FP)) && (v_cnt <= YW'(V_ACTIVE + V_FP + V_SYNC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // The pixel that loads (0,0) already uses the incoming mode, so the new mode covers the whole frame.
  always_comb begin
    mode_eff = at_origin ? mode : mode_q;
    rgb_on   = {sw_r, sw_g, sw_b};
`ifdef VGA_TEST_PATTERN_EN
    case (mode_eff)
      2'd1: rgb_on = 3'(h_cnt / XW'(H_ACTIVE / 8));
      2'd2: rgb_on = {3{|((32'(h_cnt) ^ 32'(v_cnt)) & 32'h20)}};
      2'd3: rgb_on = {3{(h_cnt == '0) || (h_cnt == XW'(H_ACTIVE - 1)) ||
                        (v_cnt == '0) || (v_cnt == YW'(V_ACTIVE - 1))}};
      default: ;
    endcase
`endif
    if (!vis) rgb_on = 3'b000;
  end

`ifndef VGA_TEST_PATTERN_EN
  logic mode_unused;
  assign mode_unused = ^mode_eff;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
      pix_tick    <= 1'b0;
      mode_q      <= 2'd0;
    end else begin
      pix_tick    <= tick;
      frame_start <= tick && at_origin;
      if (tick) begin
        hsync  <= hs_on ? SYNC_POL : ~SYNC_POL;
        vsync  <= vs_on ? SYNC_POL : ~SYNC_POL;
        active <= vis;
        pix_x  <= h_cnt;
        pix_y  <= v_cnt;
        r      <= rgb_on[2] ? {COLOR_W{1'b1}} : '0;
        g      <= rgb_on[1] ? {COLOR_W{1'b1}} : '0;
        b      <= rgb_on[0] ? {COLOR_W{1'b1}} : '0;
        if (at_origin) mode_q <= mode;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default timing, a tiny CLK_DIV=1 raster and a mid-size raster for colour modes.
// Expected colours follow VGA_TEST_PATTERN_EN: with it undefined every mode is expected to look like mode 0.
module tb_vga_timing_gen;

`ifdef VGA_TEST_PATTERN_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // C: default parameters
  logic       c_rst_n = 1'b0;
  logic [1:0] c_mode = 2'd0;
  logic       c_sw_r = 1'b1, c_sw_g = 1'b0, c_sw_b = 1'b0;
  logic       c_hsync, c_vsync, c_active, c_frame_start, c_pix_tick;
  logic [3:0] c_r, c_g, c_b;
  logic [9:0] c_pix_x, c_pix_y;

  vga_timing_gen u_c (
    .clk(clk), .rst_n(c_rst_n), .mode(c_mode), .sw_r(c_sw_r), .sw_g(c_sw_g), .sw_b(c_sw_b),
    .hsync(c_hsync), .vsync(c_vsync), .r(c_r), .g(c_g), .b(c_b), .pix_x(c_pix_x), .pix_y(c_pix_y),
    .active(c_active), .frame_start(c_frame_start), .pix_tick(c_pix_tick));

  // A: tiny raster, 12x7, active-high sync
  logic       a_rst_n = 1'b0;
  logic [1:0] a_mode = 2'd0;
  logic       a_sw_r = 1'b1, a_sw_g = 1'b1, a_sw_b = 1'b1;
  logic       a_hsync, a_vsync, a_active, a_frame_start, a_pix_tick;
  logic [3:0] a_r, a_g, a_b;
  logic [3:0] a_pix_x;
  logic [2:0] a_pix_y;

  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)) u_a (
    .clk(clk), .rst_n(a_rst_n), .mode(a_mode), .sw_r(a_sw_r), .sw_g(a_sw_g), .sw_b(a_sw_b),
    .hsync(a_hsync), .vsync(a_vsync), .r(a_r), .g(a_g), .b(a_b), .pix_x(a_pix_x), .pix_y(a_pix_y),
    .active(a_active), .frame_start(a_frame_start), .pix_tick(a_pix_tick));

  // B: 80x46 raster, 64x40 visible
  logic       b_rst_n = 1'b0;
  logic [1:0] b_mode = 2'd0;
  logic       b_sw_r = 1'b0, b_sw_g = 1'b0, b_sw_b = 1'b0;
  logic       b_hsync, b_vsync, b_active, b_frame_start, b_pix_tick;
  logic [3:0] b_r, b_g, b_b;
  logic [6:0] b_pix_x;
  logic [5:0] b_pix_y;

  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
                   .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(2)) u_b (
    .clk(clk), .rst_n(b_rst_n), .mode(b_mode), .sw_r(b_sw_r), .sw_g(b_sw_g), .sw_b(b_sw_b),
    .hsync(b_hsync), .vsync(b_vsync), .r(b_r), .g(b_g), .b(b_b), .pix_x(b_pix_x), .pix_y(b_pix_y),
    .active(b_active), .frame_start(b_frame_start), .pix_tick(b_pix_tick));

  typedef struct {
    logic [1:0] mode;
    logic [2:0] sw;
    int         x;
    int         y;
    logic [2:0] pat;
    logic       act;
    string      name;
  } vec_t;

  localparam int NV = 19;
  vec_t tv [NV];

  task automatic wait_b(input int x, input int y, input bit need_fs, output bit found);
    bit seen = !need_fs;
    found = 1'b0;
    for (int n = 0; n < 8000 && !found; n++) begin
      @(negedge clk);
      if (b_pix_tick && b_frame_start) seen = 1'b1;
      if (seen && b_pix_tick && int'(b_pix_x) == x && int'(b_pix_y) == y) found = 1'b1;
    end
  endtask

  task automatic check_b_rgb(input string name, input logic [2:0] e);
    check({name, " r"}, int'(b_r), e[2] ? 15 : 0);
    check({name, " g"}, int'(b_g), e[1] ? 15 : 0);
    check({name, " b"}, int'(b_b), e[0] ? 15 : 0);
  endtask

  initial begin
    int k, cnt, lo, per, act_cnt, bad;
    int ex, ey, e_x, e_y, e_hs, e_vs, e_act, e_fs, e_col;
    bit found, need;
    logic [2:0] e;

    tv[0]  = '{2'd0, 3'b100,  5,  3, 3'b000, 1'b1, "m0 red"};
    tv[1]  = '{2'd0, 3'b011, 10,  3, 3'b000, 1'b1, "m0 cyan"};
    tv[2]  = '{2'd0, 3'b111, 66,  3, 3'b000, 1'b0, "m0 hblank"};
    tv[3]  = '{2'd0, 3'b111,  5, 41, 3'b000, 1'b0, "m0 vblank"};
    tv[4]  = '{2'd1, 3'b010,  0,  0, 3'b000, 1'b1, "bars x0"};
    tv[5]  = '{2'd1, 3'b010,  7,  0, 3'b000, 1'b1, "bars x7"};
    tv[6]  = '{2'd1, 3'b010,  8,  0, 3'b001, 1'b1, "bars x8"};
    tv[7]  = '{2'd1, 3'b010, 20,  1, 3'b010, 1'b1, "bars x20"};
    tv[8]  = '{2'd1, 3'b010, 63,  1, 3'b111, 1'b1, "bars x63"};
    tv[9]  = '{2'd1, 3'b010, 70,  1, 3'b000, 1'b0, "bars blank"};
    tv[10] = '{2'd2, 3'b001, 31,  0, 3'b000, 1'b1, "chk 31,0"};
    tv[11] = '{2'd2, 3'b001, 32,  0, 3'b111, 1'b1, "chk 32,0"};
    tv[12] = '{2'd2, 3'b001,  0, 32, 3'b111, 1'b1, "chk 0,32"};
    tv[13] = '{2'd2, 3'b001, 32, 32, 3'b000, 1'b1, "chk 32,32"};
    tv[14] = '{2'd3, 3'b100,  0,  0, 3'b111, 1'b1, "brd 0,0"};
    tv[15] = '{2'd3, 3'b100,  5,  5, 3'b000, 1'b1, "brd 5,5"};
    tv[16] = '{2'd3, 3'b100, 63,  5, 3'b111, 1'b1, "brd 63,5"};
    tv[17] = '{2'd3, 3'b100,  5, 39, 3'b111, 1'b1, "brd 5,39"};
    tv[18] = '{2'd3, 3'b100,  5, 44, 3'b000, 1'b0, "brd vblank"};

    // ---- C: reset values, first frame_start, line timing ----
    repeat (3) @(negedge clk);
    check("c rst hsync", int'(c_hsync), 1);
    check("c rst vsync", int'(c_vsync), 1);
    check("c rst r", int'(c_r), 0);
    check("c rst active", int'(c_active), 0);
    check("c rst fs", int'(c_frame_start), 0);
    check("c rst tick", int'(c_pix_tick), 0);
    c_rst_n = 1'b1;
    k = 0;
    for (int n = 1; n <= 8 && k == 0; n++) begin
      @(negedge clk);
      if (c_frame_start) k = n;
    end
    check("c first fs edge", k, 4);
    check("c first pix_x", int'(c_pix_x), 0);

    act_cnt = 0; bad = 0;
    for (int n = 0; n < 3200; n++) begin
      if (n > 0) @(negedge clk);
      if (c_pix_tick && c_active) begin
        act_cnt++;
        if (c_r != 4'hF || c_g != 4'h0 || c_b != 4'h0) bad++;
      end else if (c_pix_tick && (c_r != 0 || c_g != 0 || c_b != 0)) begin
        bad++;
      end
    end
    check("c active px per line", act_cnt, 640);
    check("c colour errors line0", bad, 0);

    cnt = 0;
    while (c_hsync && cnt < 4000) begin @(negedge clk); cnt++; end
    check("c hsync fall seen", int'(c_hsync), 0);
    lo = 0; per = 0;
    while (!c_hsync && per < 4000) begin @(negedge clk); lo++; per++; end
    while (c_hsync && per < 4000) begin @(negedge clk); per++; end
    check("c hsync low clks", lo, 384);
    check("c hsync period clks", per, 3200);

    cnt = 0;
    while (!c_active && cnt < 4000) begin @(negedge clk); cnt++; end
    repeat (40) @(negedge clk);
    check("c active before reset", int'(c_active), 1);
    #3 c_rst_n = 1'b0;
    #1;
    check("c async rst active", int'(c_active), 0);
    check("c async rst r", int'(c_r), 0);
    check("c async rst hsync", int'(c_hsync), 1);
    check("c async rst pix_x", int'(c_pix_x), 0);
    @(negedge clk);
    c_rst_n = 1'b1;
    k = 0;
    for (int n = 1; n <= 8 && k == 0; n++) begin
      @(negedge clk);
      if (c_frame_start) k = n;
    end
    check("c fs edge after rst", k, 4);

    // ---- A: tiny raster, every pixel of one frame plus the wrap ----
    check("a rst hsync", int'(a_hsync), 0);
    check("a rst vsync", int'(a_vsync), 0);
    @(negedge clk);
    a_rst_n = 1'b1;
    k = 0;
    for (int n = 1; n <= 4 && k == 0; n++) begin
      @(negedge clk);
      if (a_frame_start) k = n;
    end
    check("a first fs edge", k, 1);
    e_x = 0; e_y = 0; e_hs = 0; e_vs = 0; e_act = 0; e_fs = 0; e_col = 0;
    for (int n = 0; n <= 84; n++) begin
      if (n > 0) @(negedge clk);
      ex = n % 12;
      ey = (n / 12) % 7;
      if (int'(a_pix_x) != ex) e_x++;
      if (int'(a_pix_y) != ey) e_y++;
      if (a_hsync != (ex == 9 || ex == 10)) e_hs++;
      if (a_vsync != (ey == 5)) e_vs++;
      if (a_active != (ex < 8 && ey < 4)) e_act++;
      if (a_frame_start != (ex == 0 && ey == 0)) e_fs++;
      if (a_r != ((ex < 8 && ey < 4) ? 4'hF : 4'h0)) e_col++;
      if (!a_pix_tick) e_x++;
    end
    check("a pix_x/tick errors", e_x, 0);
    check("a pix_y errors", e_y, 0);
    check("a hsync errors", e_hs, 0);
    check("a vsync errors", e_vs, 0);
    check("a active errors", e_act, 0);
    check("a frame_start errors", e_fs, 0);
    check("a colour errors", e_col, 0);

    // ---- B: colour-mode vector table ----
    b_mode = tv[0].mode;
    {b_sw_r, b_sw_g, b_sw_b} = tv[0].sw;
    @(negedge clk);
    b_rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      need = (i == 0) || (tv[i].mode != tv[(i > 0) ? i - 1 : 0].mode);
      b_mode = tv[i].mode;
      {b_sw_r, b_sw_g, b_sw_b} = tv[i].sw;
      wait_b(tv[i].x, tv[i].y, need, found);
      if (!found) begin
        check({tv[i].name, " reached"}, 0, 1);
      end else begin
        e = (PAT_EN && tv[i].mode != 2'd0) ? tv[i].pat : tv[i].sw;
        if (!tv[i].act) e = 3'b000;
        check({tv[i].name, " active"}, int'(b_active), int'(tv[i].act));
        check_b_rgb(tv[i].name, e);
      end
    end

    // ---- B: mid-frame mode change waits for the next frame ----
    wait_b(0, 10, 1'b1, found);
    check("latch reach 0,10", int'(found), 1);
    b_mode = 2'd2;
    wait_b(0, 20, 1'b0, found);
    check("latch reach 0,20", int'(found), 1);
    check_b_rgb("latch old mode 0,20", PAT_EN ? 3'b111 : 3'b100);
    wait_b(32, 0, 1'b1, found);
    check("latch reach 32,0", int'(found), 1);
    check_b_rgb("latch new mode 32,0", PAT_EN ? 3'b111 : 3'b100);
    wait_b(32, 32, 1'b0, found);
    check("latch reach 32,32", int'(found), 1);
    check_b_rgb("latch new mode 32,32", PAT_EN ? 3'b000 : 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
